// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared helpers for the regfile writeback arbiter
//
// Purpose: width helper used by the arbiter top and its round-robin picker.
// Ports: none (package).

package regfile_wb_arbiter_pkg;

  // Bits needed to index n entries; never returns 0 so single-entry
  // vectors still get a legal [0:0] range.
  function automatic int safe_clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rtl/regfile_wb_arbiter_rr.sv - round-robin picker for the long-latency writeback requesters
//
// Purpose: picks the first valid requester at or after the rotating pointer,
//          wrapping, and advances the pointer past a granted index.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset (pointer -> 0)
//   en_i            a grant may be issued this cycle
//   v_i             per-requester valid
//   grant_o         one-hot winner (all zero when en_i=0 or no valid)

module regfile_wb_arbiter_rr
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int num_lat_p = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic [num_lat_p-1:0] v_i,
  output logic [num_lat_p-1:0] grant_o
);

  localparam int ptr_width_lp = safe_clog2(num_lat_p);

  logic [ptr_width_lp-1:0] ptr_r;
  logic [ptr_width_lp-1:0] ptr_n;
  logic                    found;
  int                      idx;

  always_comb begin
    grant_o = '0;
    ptr_n   = ptr_r;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < num_lat_p; i++) begin
      idx = int'(ptr_r) + i;
      if (idx >= num_lat_p) begin
        idx = idx - num_lat_p;
      end
      if (en_i && !found && v_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_n        = (idx == num_lat_p - 1) ? '0 : ptr_width_lp'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else if (found) begin
      ptr_r <= ptr_n;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile write-port arbiter: pipeline writeback vs long-latency returners
//
// Purpose: the pipeline writeback owns the write port by default; long-latency
//          returners are served round-robin in idle slots, and a shared
//          starvation counter forces one of them in by stalling the pipeline
//          for a single cycle.
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   pipe_v_i/pipe_addr_i/pipe_data_i    pipeline writeback (held while stalled)
//   stall_pipe_o                        pipeline write not taken this cycle
//   lat_v_i/lat_addr_i/lat_data_i       packed long-latency requests
//   lat_yumi_o                          one-hot, request consumed this cycle
//   w_v_o/w_addr_o/w_data_o             regfile write port

module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int num_lat_p         = 3,
  parameter int starve_limit_p    = 8,
  parameter int x0_tied_to_zero_p = 1,
  localparam int addr_width_lp    = safe_clog2(els_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               pipe_v_i,
  input  logic [addr_width_lp-1:0]           pipe_addr_i,
  input  logic [width_p-1:0]                 pipe_data_i,
  output logic                               stall_pipe_o,
  input  logic [num_lat_p-1:0]               lat_v_i,
  input  logic [num_lat_p*addr_width_lp-1:0] lat_addr_i,
  input  logic [num_lat_p*width_p-1:0]       lat_data_i,
  output logic [num_lat_p-1:0]               lat_yumi_o,
  output logic                               w_v_o,
  output logic [addr_width_lp-1:0]           w_addr_o,
  output logic [width_p-1:0]                 w_data_o
);

  localparam int                      cnt_width_lp  = safe_clog2(starve_limit_p + 1);
  localparam logic [cnt_width_lp-1:0] starve_max_lp = cnt_width_lp'(starve_limit_p);

  logic [cnt_width_lp-1:0] starve_cnt_r;
  logic                    lat_any;
  logic                    override;
  logic                    rr_en;
  logic                    pipe_grant;
  logic                    lat_grant;
  logic [num_lat_p-1:0]    rr_grant;
  logic [num_lat_p:0]      sel;
  logic [addr_width_lp-1:0] mux_addr;
  logic [width_p-1:0]       mux_data;

  assign lat_any  = |lat_v_i;
  assign override = lat_any & (starve_cnt_r == starve_max_lp);

  // The picker only runs in slots the pipeline leaves free or surrenders.
  assign rr_en = ~reset_i & lat_any & (~pipe_v_i | override);

  regfile_wb_arbiter_rr #(
    .num_lat_p(num_lat_p)
  ) rr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (rr_en),
    .v_i    (lat_v_i),
    .grant_o(rr_grant)
  );

  assign lat_grant    = |rr_grant;
  assign pipe_grant   = ~reset_i & pipe_v_i & ~override;
  assign stall_pipe_o = ~reset_i & pipe_v_i & override;
  assign lat_yumi_o   = rr_grant;

  // One-hot mux: bit 0 is the pipeline, bit k+1 is requester k.
  assign sel = {rr_grant, pipe_grant};

  always_comb begin
    mux_addr = '0;
    mux_data = '0;
    if (sel[0]) begin
      mux_addr = pipe_addr_i;
      mux_data = pipe_data_i;
    end
    for (int i = 0; i < num_lat_p; i++) begin
      if (sel[i+1]) begin
        mux_addr = mux_addr | lat_addr_i[i*addr_width_lp +: addr_width_lp];
        mux_data = mux_data | lat_data_i[i*width_p +: width_p];
      end
    end
  end

  assign w_addr_o = mux_addr;
  assign w_data_o = mux_data;

  // Writes to x0 still complete their handshake; only the enable is dropped.
  assign w_v_o = (pipe_grant | lat_grant) &
                 ~((x0_tied_to_zero_p != 0) & (mux_addr == '0));

  // One counter shared by all requesters: counts cycles where someone is
  // waiting and the pipeline took the port, saturating at the override point.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_cnt_r <= '0;
    end else if (lat_grant || !lat_any) begin
      starve_cnt_r <= '0;
    end else if (!override) begin
      starve_cnt_r <= starve_cnt_r + cnt_width_lp'(1);
    end
  end

  a_yumi_onehot : assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(lat_yumi_o));

  a_single_source : assert property (@(posedge clk_i) disable iff (reset_i)
    !((|lat_yumi_o) && pipe_grant));

  for (genvar g = 0; g < num_lat_p; g++) begin : g_stable
    a_lat_hold : assert property (@(posedge clk_i) disable iff (reset_i)
      (lat_v_i[g] && !lat_yumi_o[g]) |=>
        (lat_v_i[g] &&
         $stable(lat_addr_i[g*addr_width_lp +: addr_width_lp]) &&
         $stable(lat_data_i[g*width_p +: width_p])));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  localparam int W     = 16;
  localparam int ELS   = 16;
  localparam int AW    = 4;
  localparam int N     = 3;
  localparam int LIM   = 4;
  localparam int BOUND = LIM + N * (LIM + 1);

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic              pipe_v_i = 1'b0;
  logic [AW-1:0]     pipe_addr_i = '0;
  logic [W-1:0]      pipe_data_i = '0;
  logic              stall_pipe_o;
  logic [N-1:0]      lat_v_i = '0;
  logic [N*AW-1:0]   lat_addr_i = '0;
  logic [N*W-1:0]    lat_data_i = '0;
  logic [N-1:0]      lat_yumi_o;
  logic              w_v_o;
  logic [AW-1:0]     w_addr_o;
  logic [W-1:0]      w_data_o;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .width_p(W), .els_p(ELS), .num_lat_p(N),
    .starve_limit_p(LIM), .x0_tied_to_zero_p(1)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .pipe_v_i(pipe_v_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
    .stall_pipe_o(stall_pipe_o),
    .lat_v_i(lat_v_i), .lat_addr_i(lat_addr_i), .lat_data_i(lat_data_i),
    .lat_yumi_o(lat_yumi_o),
    .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_le(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      failures++;
      $display("FAIL %s actual=%0d required<=%0d t=%0t", name, act, lim, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    pipe_v_i = 1'b0;
    lat_v_i  = '0;
    step();
    reset_i = 1'b0;
  endtask

  // Reference model: spec-level arbitration with a rotating priority index
  // and a shared starvation count; checked against the DUT every cycle.
  int            m_ptr = 0;
  int            m_starve = 0;
  logic [W-1:0]  mrf [ELS];
  logic [W-1:0]  drf [ELS];

  always @(negedge clk) begin : cmp
    int            win;
    int            idx;
    bit            any, ov, gp, gl, ewv, est;
    logic [N-1:0]  ey;
    logic [AW-1:0] ea;
    logic [W-1:0]  ed;
    any = (lat_v_i != '0);
    ov = 0; gp = 0; gl = 0; win = -1; ea = '0; ed = '0; ey = '0;
    if (!reset_i) begin
      ov = any && (m_starve == LIM);
      if (pipe_v_i && !ov) begin
        gp = 1;
        ea = pipe_addr_i;
        ed = pipe_data_i;
      end else if (any) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (win < 0 && lat_v_i[idx]) win = idx;
        end
        gl = 1;
        ey = N'(1 << win);
        ea = lat_addr_i[win*AW +: AW];
        ed = lat_data_i[win*W +: W];
      end
    end
    est = !reset_i && pipe_v_i && ov;
    ewv = (gp || gl) && (ea != '0);
    chk("m_w_v", 32'(w_v_o), 32'(ewv));
    chk("m_yumi", 32'(lat_yumi_o), 32'(ey));
    chk("m_stall", 32'(stall_pipe_o), 32'(est));
    if (gp || gl) begin
      chk("m_w_addr", 32'(w_addr_o), 32'(ea));
      chk("m_w_data", 32'(w_data_o), 32'(ed));
    end
    if (ewv) mrf[ea] = ed;
    if (w_v_o) drf[w_addr_o] = w_data_o;
    if (reset_i) begin
      m_ptr = 0;
      m_starve = 0;
    end else if (gl) begin
      m_ptr = (win + 1) % N;
      m_starve = 0;
    end else if (!any) begin
      m_starve = 0;
    end else if (m_starve < LIM) begin
      m_starve = m_starve + 1;
    end
  end

  logic [N-1:0] y;
  logic         s;
  int           wt [N];
  int           pp, pl;

  initial begin
    for (int a = 0; a < ELS; a++) begin
      mrf[a] = '0;
      drf[a] = '0;
    end
    step();
    do_reset();

    // Reset-state outputs already exercised by the model; pin one literal too.
    @(negedge clk);
    chk("rst_idle_w_v", 32'(w_v_o), 32'(0));
    step();

    // Pipeline write with no long-latency traffic.
    pipe_v_i = 1'b1; pipe_addr_i = 4'd5; pipe_data_i = 16'h00A5;
    @(negedge clk);
    chk("t1_w_v", 32'(w_v_o), 32'(1));
    chk("t1_w_addr", 32'(w_addr_o), 32'(5));
    chk("t1_w_data", 32'(w_data_o), 32'h00A5);
    chk("t1_stall", 32'(stall_pipe_o), 32'(0));
    step();
    pipe_v_i = 1'b0;

    // Round-robin rotation with all three requesters held valid.
    do_reset();
    lat_v_i = 3'b111;
    for (int i = 0; i < N; i++) begin
      lat_addr_i[i*AW +: AW] = AW'(i + 1);
      lat_data_i[i*W +: W]   = W'(16'h0100 * (i + 1));
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t2_yumi", 32'(lat_yumi_o), 32'(1 << (c % 3)));
      chk("t2_w_addr", 32'(w_addr_o), 32'((c % 3) + 1));
      step();
    end
    lat_v_i = '0;

    // Starvation override after LIM denied cycles.
    do_reset();
    pipe_v_i = 1'b1; pipe_addr_i = 4'd3; pipe_data_i = 16'h1111;
    lat_v_i = 3'b010; lat_addr_i[AW +: AW] = 4'd7; lat_data_i[W +: W] = 16'h7777;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("t3_ovr_yumi", 32'(lat_yumi_o), 32'(3'b010));
        chk("t3_ovr_stall", 32'(stall_pipe_o), 32'(1));
        chk("t3_ovr_addr", 32'(w_addr_o), 32'(7));
        chk("t3_ovr_data", 32'(w_data_o), 32'h7777);
      end else begin
        chk("t3_yumi", 32'(lat_yumi_o), 32'(0));
        chk("t3_stall", 32'(stall_pipe_o), 32'(0));
        chk("t3_addr", 32'(w_addr_o), 32'(3));
      end
      step();
      if (c == 4) lat_v_i = '0;
    end
    pipe_v_i = 1'b0;

    // x0 writes complete but never reach the regfile.
    do_reset();
    lat_v_i = 3'b001; lat_addr_i[0 +: AW] = 4'd0; lat_data_i[0 +: W] = 16'h0055;
    @(negedge clk);
    chk("t4_lat_yumi", 32'(lat_yumi_o), 32'(3'b001));
    chk("t4_lat_w_v", 32'(w_v_o), 32'(0));
    step();
    lat_v_i = '0;
    pipe_v_i = 1'b1; pipe_addr_i = 4'd0; pipe_data_i = 16'h0066;
    @(negedge clk);
    chk("t4_pipe_w_v", 32'(w_v_o), 32'(0));
    chk("t4_pipe_stall", 32'(stall_pipe_o), 32'(0));
    step();
    pipe_v_i = 1'b0;

    // Reset landing on the override cycle.
    do_reset();
    pipe_v_i = 1'b1; pipe_addr_i = 4'd2; pipe_data_i = 16'h2222;
    lat_v_i = 3'b111;
    for (int i = 0; i < N; i++) begin
      lat_addr_i[i*AW +: AW] = AW'(9 + i);
      lat_data_i[i*W +: W]   = W'(16'h0900 + i);
    end
    for (int c = 0; c < LIM; c++) begin
      @(negedge clk);
      chk("t5_pre_stall", 32'(stall_pipe_o), 32'(0));
      step();
    end
    reset_i = 1'b1;
    @(negedge clk);
    chk("t5_rst_w_v", 32'(w_v_o), 32'(0));
    chk("t5_rst_yumi", 32'(lat_yumi_o), 32'(0));
    chk("t5_rst_stall", 32'(stall_pipe_o), 32'(0));
    step();
    reset_i = 1'b0;
    @(negedge clk);
    chk("t5_post_w_v", 32'(w_v_o), 32'(1));
    chk("t5_post_addr", 32'(w_addr_o), 32'(2));
    chk("t5_post_yumi", 32'(lat_yumi_o), 32'(0));
    chk("t5_post_stall", 32'(stall_pipe_o), 32'(0));
    step();
    do_reset();

    // Random traffic with protocol-compliant holding.
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      case (cyc / 2500)
        0: begin pp = 30; pl = 20; end
        1: begin pp = 70; pl = 50; end
        2: begin pp = 95; pl = 10; end
        default: begin pp = 50; pl = 80; end
      endcase
      @(negedge clk);
      y = lat_yumi_o;
      s = stall_pipe_o;
      for (int i = 0; i < N; i++) begin
        if (lat_v_i[i]) begin
          if (y[i]) begin
            chk_le("lat_wait", wt[i], BOUND);
            wt[i] = 0;
          end else begin
            wt[i] = wt[i] + 1;
          end
        end
      end
      step();
      if (!(pipe_v_i && s)) begin
        pipe_v_i    = (($urandom % 100) < 32'(pp));
        pipe_addr_i = AW'($urandom);
        pipe_data_i = W'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if (!lat_v_i[i] || y[i]) begin
          lat_v_i[i]             = (($urandom % 100) < 32'(pl));
          lat_addr_i[i*AW +: AW] = AW'($urandom);
          lat_data_i[i*W +: W]   = W'($urandom);
        end
      end
    end

    for (int i = 0; i < N; i++) begin
      if (lat_v_i[i]) chk_le("lat_pending_wait", wt[i], BOUND);
    end
    for (int a = 0; a < ELS; a++) begin
      chk("regfile", 32'(drf[a]), 32'(mrf[a]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
